ddr_burst_sched: RTL
====================

DDR_BURST_SCHED -- requirements
Module: ddr_burst_sched
Interface
REQ-001 SHALL have parameter QDEPTH, default 8: entries in each of the request, CAS and RW queues (power of 2, at least 2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: physical address width.
REQ-003 SHALL have parameter TA_WIDTH, default 29: mapped memory address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64: DQ beat width.
REQ-005 SHALL have ports (name, direction, width, meaning), one per line:
- clock_t  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request offer.
- req_ready  out  1  request queue not full.
- req_rw  in  2  01=READ, 10=WRITE.
- req_addr  in  ADDR_WIDTH  physical address.
- req_wdata  in  8*DATA_WIDTH  write burst, beat 0 in the LSBs.
- cmd_rdy  in  7  strobes: [0]ACT [1]CAS [2]MRS [3]DES [4]PRE [5]REF [6]ZQCL.
- rw_rdy  in  1  start data burst.
- mode_reg  in  18  MRS/DES/ZQCL payload.
- pre_reg  in  18  PRE payload.
- cmd_valid  out  1  a non-NOP command is present.
- cmd_code  out  4  0 NOP, 1 ACT, 2 CAS_R, 3 CAS_W, 4 MRS, 5 PRE, 6 REF, 7 ZQCL, 8 DES.
- cmd_addr  out  TA_WIDTH  command address.
- dq_out  out  DATA_WIDTH  write beat.
- dq_valid  out  1  dq_out is valid.
- dqs_en  out  1  strobe enable (preamble plus data).
- dimm_rd  out  1  read burst in progress.
- burst_len  out  4  current BL, 4 or 8.
- rd_delay  out  6  CL+AL-RPRE.
- wr_delay  out  6  CWL+AL-WPRE.
- tccd  out  4  CAS-to-CAS delay.
- err  out  5  sticky: [0] ACT on empty or blocked, [1] CAS on empty, [2] RW on empty, [3] rw_rdy while busy, [4] strobe conflict.
Function
REQ-006 SHALL push {rw, mapped addr, wdata} into the request queue on req_valid&&req_ready; req_ready SHALL be 1 while the queue holds fewer than QDEPTH entries; a push while full SHALL be ignored.
REQ-007 SHALL map mem_addr[i]=req_addr[i+3] for i=0..TA_WIDTH-1 (straight mapping); TA_WIDTH+3 SHALL NOT exceed ADDR_WIDTH.
REQ-008 SHALL grant at most one command per cycle, priority ZQCL>REF>PRE>DES>MRS>CAS>ACT; when more than one strobe is set, err[4] SHALL set and non-granted ACT/CAS SHALL NOT pop any queue.
REQ-009 SHALL register command outputs: a strobe sampled at edge N SHALL drive cmd_code/cmd_addr/cmd_valid after edge N for exactly one cycle; with no grant, outputs SHALL be NOP, addr all-ones, cmd_valid 0.
REQ-010 An ACT grant SHALL pop the request head, issue ACT with its address, and push to the CAS and RW queues; if the request queue is empty or either of those queues is full, SHALL issue NOP, pop nothing and set err[0].
REQ-011 A CAS grant SHALL pop the CAS head and issue CAS_R or CAS_W with its address; on empty SHALL issue NOP and set err[1].
REQ-012 MRS/DES/ZQCL SHALL drive cmd_addr={mode_reg, 10'b1}, PRE SHALL drive {pre_reg, 10'b1} and REF all-ones, each truncated to TA_WIDTH LSBs.
REQ-013 SHALL update timing on an MRS grant using mode_reg[17:15]:
- MR0: CL=9+[6:3] if that field is below 12; BL=4 if [1:0]==2, else 8.
- MR1: AL=CL-[4:3] if that field is 1 or 2, else 0.
- MR2: CWL=9+[5:3] if that field is below 7.
- MR4: RPRE=[11]+1, WPRE=[12]+1.
- MR6: tCCD=4+[12:10].
- Other MR values: no change.
REQ-014 SHALL implement a burst FSM IDLE->PRE->DATA->IDLE; rw_rdy in IDLE SHALL pop the RW head and enter PRE.
REQ-015 PRE SHALL last WPRE cycles for a write with dqs_en=1, and zero cycles for a read.
REQ-016 DATA SHALL last BL cycles; a write SHALL drive beat k on dq_out with dq_valid=dqs_en=1, and a read SHALL hold dimm_rd=1.
REQ-017 SHALL ignore rw_rdy outside IDLE and set err[3]; rw_rdy with the RW queue empty SHALL stay IDLE and set err[2].
REQ-018 SHALL allow a same-cycle push and pop on any queue, leaving the count unchanged, with pointers wrapping modulo QDEPTH.
Reset
REQ-019 While reset_n=0: queues empty, FSM IDLE, cmd NOP with addr all-ones, cmd_valid/dq_valid/dqs_en/dimm_rd=0, dq_out=0, err=0, CL=CWL=9, AL=0, BL=8, RPRE=WPRE=1, tCCD=4; reset mid-burst SHALL abort the burst immediately.
Verification
REQ-020 MRS with MR0 [6:3]=3 and [1:0]=2, then MR1 [4:3]=1 -> CL=12, BL=4, AL=11, rd_delay=22.
REQ-021 WRITE addr 0x00000040, then ACT, CAS, rw_rdy, with WPRE=2 and BL=8 -> ACT then CAS_W with cmd_addr=8; dqs_en for 10 cycles; dq_valid for beats 0..7.
REQ-022 QDEPTH+1 back-to-back requests -> req_ready=0 after QDEPTH pushes; the extra request is dropped.
REQ-023 ACT and REF strobes in the same cycle -> REF issued, err[4]=1, request queue count unchanged.
REQ-024 cas_rdy with the CAS queue empty -> NOP, err[1]=1; then reset_n pulse -> err=0 and all queues empty.

Source files
------------

// File: rtl/ddr_burst_sched.sv
// DDR command/burst scheduler: request, CAS and RW queues feeding a one-grant-per-cycle
// command port, MRS-driven timing registers, and a write/read data burst engine.
//
// burst state | meaning
// B_IDLE      | waiting for rw_rdy; pops the RW head on start
// B_PRE       | write preamble, dqs_en high for WPRE cycles
// B_DATA      | BL beats: write drives dq_out, read holds dimm_rd

module ddr_burst_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock_t,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock_t) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

module ddr_burst_sched #(
    parameter int QDEPTH     = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int TA_WIDTH   = 29,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clock_t,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [8*DATA_WIDTH-1:0] req_wdata,
    input  logic [6:0]              cmd_rdy,
    input  logic                    rw_rdy,
    input  logic [17:0]             mode_reg,
    input  logic [17:0]             pre_reg,
    output logic                    cmd_valid,
    output logic [3:0]              cmd_code,
    output logic [TA_WIDTH-1:0]     cmd_addr,
    output logic [DATA_WIDTH-1:0]   dq_out,
    output logic                    dq_valid,
    output logic                    dqs_en,
    output logic                    dimm_rd,
    output logic [3:0]              burst_len,
    output logic [5:0]              rd_delay,
    output logic [5:0]              wr_delay,
    output logic [3:0]              tccd,
    output logic [4:0]              err
);
    localparam int WBITS    = 8*DATA_WIDTH;
    localparam int REQ_BITS = 2 + TA_WIDTH + WBITS;
    localparam int CAS_BITS = 2 + TA_WIDTH;
    localparam int RW_BITS  = 2 + WBITS;

    localparam logic [3:0] CODE_NOP  = 4'd0;
    localparam logic [3:0] CODE_ACT  = 4'd1;
    localparam logic [3:0] CODE_CASR = 4'd2;
    localparam logic [3:0] CODE_CASW = 4'd3;
    localparam logic [3:0] CODE_MRS  = 4'd4;
    localparam logic [3:0] CODE_PRE  = 4'd5;
    localparam logic [3:0] CODE_REF  = 4'd6;
    localparam logic [3:0] CODE_ZQCL = 4'd7;
    localparam logic [3:0] CODE_DES  = 4'd8;

    typedef enum logic [1:0] {B_IDLE, B_PRE, B_DATA} burst_t;

    // Register payloads are 28 bits; zero-extend or truncate to the command address width.
    function automatic logic [TA_WIDTH-1:0] fit_addr(input logic [27:0] v);
        logic [TA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < TA_WIDTH && i < 28; i++) r[i] = v[i];
        return r;
    endfunction

    logic [TA_WIDTH-1:0] mem_addr;
    logic                addr_unused;
    assign mem_addr    = req_addr[TA_WIDTH+2:3];
    assign addr_unused = ^req_addr;

    logic [REQ_BITS-1:0] req_head;
    logic [CAS_BITS-1:0] cas_head;
    logic [RW_BITS-1:0]  rw_head;
    logic req_full, req_empty, cas_full, cas_empty, rw_full, rw_empty;
    logic act_ok, cas_go, rw_pop;

    ddr_burst_sched_fifo #(.DEPTH(QDEPTH), .WIDTH(REQ_BITS)) u_req_q (
        .clock_t(clock_t), .reset_n(reset_n),
        .push(req_valid && req_ready), .pop(act_ok),
        .wr_data({req_rw, mem_addr, req_wdata}), .rd_data(req_head),
        .full(req_full), .empty(req_empty)
    );

    ddr_burst_sched_fifo #(.DEPTH(QDEPTH), .WIDTH(CAS_BITS)) u_cas_q (
        .clock_t(clock_t), .reset_n(reset_n),
        .push(act_ok), .pop(cas_go),
        .wr_data(req_head[REQ_BITS-1:WBITS]), .rd_data(cas_head),
        .full(cas_full), .empty(cas_empty)
    );

    ddr_burst_sched_fifo #(.DEPTH(QDEPTH), .WIDTH(RW_BITS)) u_rw_q (
        .clock_t(clock_t), .reset_n(reset_n),
        .push(act_ok), .pop(rw_pop),
        .wr_data({req_head[REQ_BITS-1 -: 2], req_head[WBITS-1:0]}), .rd_data(rw_head),
        .full(rw_full), .empty(rw_empty)
    );

    assign req_ready = !req_full;

    // Highest strobe index wins, which matches ZQCL > REF > PRE > DES > MRS > CAS > ACT.
    logic [6:0]          gnt;
    logic                conflict;
    logic [3:0]          code_nxt;
    logic [TA_WIDTH-1:0] addr_nxt;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < 7; i++) begin
            if (cmd_rdy[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

    assign conflict = (cmd_rdy & (cmd_rdy - 7'd1)) != 7'd0;
    assign act_ok   = gnt[0] && !req_empty && !cas_full && !rw_full;
    assign cas_go   = gnt[1] && !cas_empty;

    always_comb begin
        code_nxt = CODE_NOP;
        addr_nxt = '1;
        if (gnt[6]) begin
            code_nxt = CODE_ZQCL;
            addr_nxt = fit_addr({mode_reg, 10'd1});
        end else if (gnt[5]) begin
            code_nxt = CODE_REF;
        end else if (gnt[4]) begin
            code_nxt = CODE_PRE;
            addr_nxt = fit_addr({pre_reg, 10'd1});
        end else if (gnt[3]) begin
            code_nxt = CODE_DES;
            addr_nxt = fit_addr({mode_reg, 10'd1});
        end else if (gnt[2]) begin
            code_nxt = CODE_MRS;
            addr_nxt = fit_addr({mode_reg, 10'd1});
        end else if (cas_go) begin
            code_nxt = (cas_head[CAS_BITS-1 -: 2] == 2'b10) ? CODE_CASW : CODE_CASR;
            addr_nxt = cas_head[TA_WIDTH-1:0];
        end else if (act_ok) begin
            code_nxt = CODE_ACT;
            addr_nxt = req_head[WBITS +: TA_WIDTH];
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cmd_code  <= CODE_NOP;
            cmd_addr  <= '1;
            cmd_valid <= 1'b0;
        end else begin
            cmd_code  <= code_nxt;
            cmd_addr  <= addr_nxt;
            cmd_valid <= (code_nxt != CODE_NOP);
        end
    end

    logic [5:0] cl, al, cwl;
    logic [1:0] rpre, wpre;

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cl        <= 6'd9;
            cwl       <= 6'd9;
            al        <= 6'd0;
            burst_len <= 4'd8;
            rpre      <= 2'd1;
            wpre      <= 2'd1;
            tccd      <= 4'd4;
        end else if (gnt[2]) begin
            case (mode_reg[17:15])
                3'd0: begin
                    if (mode_reg[6:3] < 4'd12) cl <= 6'd9 + {2'b00, mode_reg[6:3]};
                    burst_len <= (mode_reg[1:0] == 2'd2) ? 4'd4 : 4'd8;
                end
                3'd1: begin
                    if (mode_reg[4:3] == 2'd1 || mode_reg[4:3] == 2'd2)
                        al <= cl - {4'b0000, mode_reg[4:3]};
                    else
                        al <= 6'd0;
                end
                3'd2: if (mode_reg[5:3] < 3'd7) cwl <= 6'd9 + {3'b000, mode_reg[5:3]};
                3'd4: begin
                    rpre <= {1'b0, mode_reg[11]} + 2'd1;
                    wpre <= {1'b0, mode_reg[12]} + 2'd1;
                end
                3'd6: tccd <= 4'd4 + {1'b0, mode_reg[12:10]};
                default: ;
            endcase
        end
    end

    assign rd_delay = cl + al - {4'b0000, rpre};
    assign wr_delay = cwl + al - {4'b0000, wpre};

    burst_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [2:0]     beat, beat_nxt;
    logic           is_wr, is_wr_nxt;
    logic [WBITS-1:0] wbuf;
    logic           err_busy, err_rw_empty;

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state <= B_IDLE;
            cnt   <= '0;
            beat  <= '0;
            is_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            beat  <= beat_nxt;
            is_wr <= is_wr_nxt;
        end
    end

    always_ff @(posedge clock_t) begin
        if (rw_pop) wbuf <= rw_head[WBITS-1:0];
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        beat_nxt     = beat;
        is_wr_nxt    = is_wr;
        rw_pop       = 1'b0;
        dqs_en       = 1'b0;
        dq_valid     = 1'b0;
        dimm_rd      = 1'b0;
        dq_out       = '0;
        err_busy     = 1'b0;
        err_rw_empty = 1'b0;
        case (state)
            B_IDLE: begin
                if (rw_rdy) begin
                    if (rw_empty) begin
                        err_rw_empty = 1'b1;
                    end else begin
                        rw_pop   = 1'b1;
                        beat_nxt = '0;
                        if (rw_head[RW_BITS-1 -: 2] == 2'b10) begin
                            is_wr_nxt = 1'b1;
                            state_nxt = B_PRE;
                            cnt_nxt   = {2'b00, wpre} - 4'd1;
                        end else begin
                            is_wr_nxt = 1'b0;
                            state_nxt = B_DATA;
                            cnt_nxt   = burst_len - 4'd1;
                        end
                    end
                end
            end
            B_PRE: begin
                dqs_en   = 1'b1;
                err_busy = rw_rdy;
                if (cnt == '0) begin
                    state_nxt = B_DATA;
                    cnt_nxt   = burst_len - 4'd1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            B_DATA: begin
                err_busy = rw_rdy;
                if (is_wr) begin
                    dqs_en   = 1'b1;
                    dq_valid = 1'b1;
                    dq_out   = wbuf[beat*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    dimm_rd = 1'b1;
                end
                if (cnt == '0) begin
                    state_nxt = B_IDLE;
                end else begin
                    cnt_nxt  = cnt - 4'd1;
                    beat_nxt = beat + 3'd1;
                end
            end
            default: state_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            err <= '0;
        end else begin
            err <= err | {conflict, err_busy, err_rw_empty, gnt[1] && cas_empty, gnt[0] && !act_ok};
        end
    end
endmodule
